mb_session_ctrl: RTL and testbench

//   Session controller for the Multibanco datapath: sequences one card session
//   (card in, PIN check with retry limit, balance query or withdrawal, card eject).

---
 rtl/mb_session_ctrl_if.sv | 41 ++++
 rtl/mb_session_ctrl.sv | 153 +++++++++++++++
 tb/tb_mb_session_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mb_session_ctrl_if.sv
// Front-end / account-side signal bundle of the Multibanco session controller.
// master = card/keypad front-end and dispenser side, slave = the controller.
interface mb_session_ctrl_if #(
  parameter int unsigned VAL_W = 4
);
  logic             CARD_IN;
  logic             PIN_VALID;
  logic [VAL_W-1:0] PIN_IN;
  logic [VAL_W-1:0] PIN_REF;
  logic             OP_VALID;
  logic             OP_SEL;
  logic [VAL_W-1:0] VAL_IN;
  logic [VAL_W-1:0] SALDO_IN;
  logic             CANCEL;
  logic             DISP_ACK;

  logic             EN;
  logic             COD_OUT;
  logic             DISP_REQ;
  logic [VAL_W-1:0] VAL_OUT;
  logic             SALDO_WE;
  logic [VAL_W-1:0] SALDO_OUT;
  logic [4:0]       ECRA;
  logic             PAR;
  logic             CARD_EJECT;
  logic             LOCKED;

  modport master (
    output CARD_IN, PIN_VALID, PIN_IN, PIN_REF, OP_VALID, OP_SEL,
           VAL_IN, SALDO_IN, CANCEL, DISP_ACK,
    input  EN, COD_OUT, DISP_REQ, VAL_OUT, SALDO_WE, SALDO_OUT,
           ECRA, PAR, CARD_EJECT, LOCKED
  );

  modport slave (
    input  CARD_IN, PIN_VALID, PIN_IN, PIN_REF, OP_VALID, OP_SEL,
           VAL_IN, SALDO_IN, CANCEL, DISP_ACK,
    output EN, COD_OUT, DISP_REQ, VAL_OUT, SALDO_WE, SALDO_OUT,
           ECRA, PAR, CARD_EJECT, LOCKED
  );
endinterface

// File: rtl/mb_session_ctrl.sv
// Multibanco session controller: card in, PIN check with retry limit,
// balance query or withdrawal, card eject. All outputs registered.
module mb_session_ctrl #(
  parameter int unsigned VAL_W     = 4,
  parameter int unsigned MAX_TRIES = 3,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic               CLK,
  input  logic               RST,
  mb_session_ctrl_if.slave   bus
);

  localparam int unsigned TRW = $clog2(MAX_TRIES + 1);
  localparam int unsigned TMW = $clog2(TIMEOUT + 1);
  localparam logic [TRW-1:0] TRIES_LAST = TRW'(MAX_TRIES - 1);
  localparam logic [TMW-1:0] TMR_LAST   = TMW'(TIMEOUT - 1);

  localparam logic [4:0] SC_IDLE    = 5'h01;
  localparam logic [4:0] SC_PIN     = 5'h02;
  localparam logic [4:0] SC_PIN_BAD = 5'h03;
  localparam logic [4:0] SC_MENU    = 5'h04;
  localparam logic [4:0] SC_BAL     = 5'h05;
  localparam logic [4:0] SC_REFUSED = 5'h06;
  localparam logic [4:0] SC_DISP    = 5'h08;
  localparam logic [4:0] SC_EJECT   = 5'h10;
  localparam logic [4:0] SC_LOCK    = 5'h1F;

  typedef enum logic [2:0] {
    S_IDLE, S_PIN_WAIT, S_MENU, S_DISPENSE, S_EJECT, S_LOCK
  } state_t;

  state_t         state;
  logic [TRW-1:0] tries;
  logic [TMW-1:0] timer;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= S_IDLE;
      tries          <= '0;
      timer          <= '0;
      bus.EN         <= 1'b0;
      bus.COD_OUT    <= 1'b0;
      bus.DISP_REQ   <= 1'b0;
      bus.VAL_OUT    <= '0;
      bus.SALDO_WE   <= 1'b0;
      bus.SALDO_OUT  <= '0;
      bus.ECRA       <= SC_IDLE;
      bus.PAR        <= 1'b0;
      bus.CARD_EJECT <= 1'b0;
      bus.LOCKED     <= 1'b0;
    end else begin
      bus.SALDO_WE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.CARD_IN) begin
            state       <= S_PIN_WAIT;
            bus.EN      <= 1'b1;
            bus.ECRA    <= SC_PIN;
            bus.COD_OUT <= 1'b0;
            tries       <= '0;
            timer       <= '0;
          end
        end

        S_PIN_WAIT, S_MENU: begin
          if (!bus.CARD_IN) begin
            state         <= S_IDLE;
            bus.EN        <= 1'b0;
            bus.ECRA      <= SC_IDLE;
            bus.VAL_OUT   <= '0;
            bus.SALDO_OUT <= '0;
            bus.PAR       <= 1'b0;
          end else if (bus.CANCEL) begin
            state          <= S_EJECT;
            bus.EN         <= 1'b0;
            bus.ECRA       <= SC_EJECT;
            bus.CARD_EJECT <= 1'b1;
          end else if (state == S_PIN_WAIT && bus.PIN_VALID) begin
            timer <= '0;
            if (bus.PIN_IN == bus.PIN_REF) begin
              state       <= S_MENU;
              bus.COD_OUT <= 1'b1;
              bus.ECRA    <= SC_MENU;
              tries       <= '0;
            end else if (tries == TRIES_LAST) begin
              state      <= S_LOCK;
              bus.EN     <= 1'b0;
              bus.ECRA   <= SC_LOCK;
              bus.LOCKED <= 1'b1;
            end else begin
              tries    <= tries + 1'b1;
              bus.ECRA <= SC_PIN_BAD;
            end
          end else if (state == S_MENU && bus.OP_VALID) begin
            timer <= '0;
            if (!bus.OP_SEL) begin
              bus.SALDO_OUT <= bus.SALDO_IN;
              bus.ECRA      <= SC_BAL;
            end else if (bus.VAL_IN == '0 || bus.VAL_IN > bus.SALDO_IN) begin
              bus.ECRA <= SC_REFUSED;
            end else begin
              state        <= S_DISPENSE;
              bus.VAL_OUT  <= bus.VAL_IN;
              bus.PAR      <= ^bus.VAL_IN;
              bus.DISP_REQ <= 1'b1;
              bus.ECRA     <= SC_DISP;
            end
          end else if (timer == TMR_LAST) begin
            state          <= S_EJECT;
            bus.EN         <= 1'b0;
            bus.ECRA       <= SC_EJECT;
            bus.CARD_EJECT <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_DISPENSE: begin
          // Balance may have moved since the request was accepted; clamp at zero.
          if (bus.DISP_ACK) begin
            state          <= S_EJECT;
            bus.DISP_REQ   <= 1'b0;
            bus.SALDO_OUT  <= (bus.SALDO_IN >= bus.VAL_OUT) ?
                              bus.SALDO_IN - bus.VAL_OUT : '0;
            bus.SALDO_WE   <= 1'b1;
            bus.EN         <= 1'b0;
            bus.ECRA       <= SC_EJECT;
            bus.CARD_EJECT <= 1'b1;
          end
        end

        S_EJECT: begin
          if (!bus.CARD_IN) begin
            state          <= S_IDLE;
            bus.CARD_EJECT <= 1'b0;
            bus.ECRA       <= SC_IDLE;
            bus.VAL_OUT    <= '0;
            bus.SALDO_OUT  <= '0;
            bus.PAR        <= 1'b0;
          end
        end

        S_LOCK: begin
          bus.LOCKED     <= 1'b1;
          bus.CARD_EJECT <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mb_session_ctrl.sv
// Directed bench for mb_session_ctrl: vector table for a full session flow,
// plus hand sequences for lock-out, timeout, cancel priority and reset abort.
module tb_mb_session_ctrl;

  logic CLK;
  logic RST;

  mb_session_ctrl_if #(.VAL_W(4)) bus();

  mb_session_ctrl #(.VAL_W(4), .MAX_TRIES(3), .TIMEOUT(15)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst, card, pv;
    logic [3:0] pin;
    logic       ov, sel;
    logic [3:0] val, saldo;
    logic       cancel, ack;
    logic [19:0] exp;
  } vec_t;

  vec_t tbl[$];

  localparam logic [19:0] RESET_SNAP = {5'h01, 15'b0};

  // {ECRA, EN, COD_OUT, DISP_REQ, VAL_OUT, SALDO_WE, SALDO_OUT, PAR, CARD_EJECT, LOCKED}
  function automatic logic [19:0] snap();
    return {bus.ECRA, bus.EN, bus.COD_OUT, bus.DISP_REQ, bus.VAL_OUT,
            bus.SALDO_WE, bus.SALDO_OUT, bus.PAR, bus.CARD_EJECT, bus.LOCKED};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input int r, input int c, input int pv, input int pin,
                     input int ov, input int sel, input int val, input int saldo,
                     input int cn, input int ak,
                     input int ecra, input int en, input int cod, input int req,
                     input int vout, input int we, input int sout,
                     input int par, input int ej, input int lk);
    vec_t v;
    v.rst = r[0];  v.card = c[0];  v.pv = pv[0];  v.pin = pin[3:0];
    v.ov = ov[0];  v.sel = sel[0]; v.val = val[3:0]; v.saldo = saldo[3:0];
    v.cancel = cn[0]; v.ack = ak[0];
    v.exp = {ecra[4:0], en[0], cod[0], req[0], vout[3:0], we[0], sout[3:0],
             par[0], ej[0], lk[0]};
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.PIN_VALID = 1'b0; bus.PIN_IN = '0;  bus.OP_VALID = 1'b0;
    bus.OP_SEL = 1'b0;    bus.VAL_IN = '0;  bus.CANCEL = 1'b0;
    bus.DISP_ACK = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    bus.CARD_IN = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  // From reset: insert card, correct PIN, withdraw VAL from balance 9.
  task automatic to_dispense(input logic [3:0] val);
    do_reset();
    bus.CARD_IN = 1'b1; tick();
    bus.PIN_VALID = 1'b1; bus.PIN_IN = 4'd5; tick();
    clear_inputs();
    bus.OP_VALID = 1'b1; bus.OP_SEL = 1'b1; bus.VAL_IN = val; tick();
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int reqcnt;
    RST = 1'b0;
    bus.PIN_REF  = 4'd5;
    bus.SALDO_IN = 4'd9;
    bus.CARD_IN  = 1'b0;
    clear_inputs();

    //   r c pv pin ov sel val sal cn ak | ecra en cod req vout we sout par ej lk
    add(1,0,0,0, 0,0,0, 9, 0,0,  'h01,0,0,0,0,0,0,0,0,0);
    add(0,1,0,0, 0,0,0, 9, 0,0,  'h02,1,0,0,0,0,0,0,0,0);
    add(0,1,1,4, 0,0,0, 9, 0,0,  'h03,1,0,0,0,0,0,0,0,0);
    add(0,1,1,5, 0,0,0, 9, 0,0,  'h04,1,1,0,0,0,0,0,0,0);
    add(0,1,0,0, 1,0,0, 9, 0,0,  'h05,1,1,0,0,0,9,0,0,0);
    add(0,1,0,0, 1,1,10,9, 0,0,  'h06,1,1,0,0,0,9,0,0,0);
    add(0,1,0,0, 1,1,0, 9, 0,0,  'h06,1,1,0,0,0,9,0,0,0);
    add(0,1,0,0, 1,1,3, 9, 0,0,  'h08,1,1,1,3,0,9,0,0,0);
    add(0,1,0,0, 0,0,0, 9, 1,0,  'h08,1,1,1,3,0,9,0,0,0);
    add(0,0,0,0, 0,0,0, 9, 0,0,  'h08,1,1,1,3,0,9,0,0,0);
    add(0,1,0,0, 0,0,0, 9, 0,1,  'h10,0,1,0,3,1,6,0,1,0);
    add(0,1,0,0, 0,0,0, 9, 0,0,  'h10,0,1,0,3,0,6,0,1,0);
    add(0,0,0,0, 0,0,0, 9, 0,0,  'h01,0,1,0,0,0,0,0,0,0);
    add(0,1,0,0, 0,0,0, 9, 0,0,  'h02,1,0,0,0,0,0,0,0,0);
    add(0,1,1,5, 0,0,0, 9, 0,0,  'h04,1,1,0,0,0,0,0,0,0);
    add(0,1,0,0, 1,1,7, 9, 0,0,  'h08,1,1,1,7,0,0,1,0,0);
    add(0,1,0,0, 0,0,0, 9, 0,1,  'h10,0,1,0,7,1,2,1,1,0);
    add(0,0,0,0, 0,0,0, 9, 0,0,  'h01,0,1,0,0,0,0,0,0,0);

    foreach (tbl[i]) begin
      RST = tbl[i].rst;            bus.CARD_IN = tbl[i].card;
      bus.PIN_VALID = tbl[i].pv;   bus.PIN_IN = tbl[i].pin;
      bus.OP_VALID = tbl[i].ov;    bus.OP_SEL = tbl[i].sel;
      bus.VAL_IN = tbl[i].val;     bus.SALDO_IN = tbl[i].saldo;
      bus.CANCEL = tbl[i].cancel;  bus.DISP_ACK = tbl[i].ack;
      tick();
      chk($sformatf("vec%0d", i), 32'(snap()), 32'(tbl[i].exp));
    end
    RST = 1'b0;
    clear_inputs();
    bus.SALDO_IN = 4'd9;

    // Three wrong PINs lock the card until reset.
    do_reset();
    bus.CARD_IN = 1'b1; tick();
    bus.PIN_VALID = 1'b1; bus.PIN_IN = 4'd4;
    tick(); chk("lock_try1_ecra", 32'(bus.ECRA), 32'h03);
    tick(); chk("lock_try2_ecra", 32'(bus.ECRA), 32'h03);
    tick(); chk("lock_try3", 32'(snap()), 32'({5'h1F, 14'b0, 1'b1}));
    clear_inputs();
    bus.CARD_IN = 1'b0; bus.CANCEL = 1'b1;
    repeat (3) tick();
    chk("lock_held", 32'(snap()), 32'({5'h1F, 14'b0, 1'b1}));
    bus.CANCEL = 1'b0;
    RST = 1'b1; tick(); RST = 1'b0;
    chk("lock_reset", 32'(snap()), 32'(RESET_SNAP));

    // Idle timeout in PIN_WAIT: 15 cycles then eject.
    do_reset();
    bus.CARD_IN = 1'b1; tick();
    n = 0;
    while (!bus.CARD_EJECT && n < 40) begin
      tick();
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'd15);
    chk("timeout_ecra", 32'(bus.ECRA), 32'h10);
    bus.CARD_IN = 1'b0; tick();
    chk("timeout_idle", 32'(snap()), 32'(RESET_SNAP));

    // CANCEL beats a correct PIN in the same cycle.
    do_reset();
    bus.CARD_IN = 1'b1; tick();
    bus.PIN_VALID = 1'b1; bus.PIN_IN = 4'd5; bus.CANCEL = 1'b1; tick();
    clear_inputs();
    chk("cancel_pin", 32'(snap()), 32'({5'h10, 13'b0, 1'b1, 1'b0}));

    // Withdrawal with ACK after 4 cycles of request.
    to_dispense(4'd3);
    reqcnt = 0;
    for (int k = 0; k < 3; k++) begin
      if (bus.DISP_REQ) reqcnt++;
      tick();
    end
    if (bus.DISP_REQ) reqcnt++;
    bus.DISP_ACK = 1'b1; tick(); bus.DISP_ACK = 1'b0;
    chk("disp_req_cycles", 32'(reqcnt), 32'd4);
    chk("disp_ack", 32'(snap()), 32'({5'h10, 1'b0, 1'b1, 1'b0, 4'd3, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0}));
    tick();
    chk("disp_we_pulse", 32'(bus.SALDO_WE), 32'd0);

    // Reset during DISPENSE aborts without a balance write, even with ACK present.
    to_dispense(4'd2);
    chk("rstdisp_pre_req", 32'(bus.DISP_REQ), 32'd1);
    RST = 1'b1; bus.DISP_ACK = 1'b1; tick();
    RST = 1'b0; bus.DISP_ACK = 1'b0;
    chk("rstdisp_reset", 32'(snap()), 32'(RESET_SNAP));
    tick();
    chk("rstdisp_no_we", 32'(bus.SALDO_WE), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
